// File: rtl/mch_pack_pkg.sv
// Shared types and layout constants for the multichannel frame packer.
// A FIFO entry is {ChIdx, Last, Data}.
package mch_pack_pkg;

    localparam int CH_W   = 4;
    localparam int NCH_W  = 5;
    localparam int META_W = CH_W + 1;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_SEQ = 1;
    localparam int FLAG_CFG = 0;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } pack_state_e;

    function automatic int entry_width(input int data_width);
        return data_width + META_W;
    endfunction

endpackage

// File: rtl/mch_pack_ram.sv
// Simple dual-port entry store: synchronous write, asynchronous read so the
// head entry can fall through to the output without a read cycle.
module mch_pack_ram
    import mch_pack_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = entry_width(24)
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/mch_frame_packer.sv
// Packs per-channel samples into frame-atomic FIFO entries. Writes advance wr,
// only a completed frame advances cm, so readers never see a partial frame.
module mch_frame_packer
    import mch_pack_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int MAX_CHANNELS = 16,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NCH_W-1:0]      Num_Ch,
    input  logic                  Clear_Status,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Data_In_Valid,
    input  logic [CH_W-1:0]       Data_In_ChIdx,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic [CH_W-1:0]       Data_Out_ChIdx,
    output logic                  Data_Out_Last,
    output logic                  Data_Out_Valid,
    input  logic                  Data_Out_Ready,
    output logic                  Overflow,
    output logic                  Seq_Err,
    output logic                  Cfg_Err,
    output logic [15:0]           Frame_Cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = entry_width(DATA_WIDTH);

    pack_state_e       state_q, state_d;
    logic [PW-1:0]     wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
    logic [CH_W-1:0]   exp_q, exp_d;
    logic [NCH_W-1:0]  nch_q, nch_d;
    logic [2:0]        flag_q, flag_d, flag_set;
    logic [15:0]       fcnt_q, fcnt_d;

    logic [PW-1:0]     wr_base, free_space, ram_waddr;
    logic              start_eval, ram_we, wr_last, commit, do_read;
    logic [EW-1:0]     ram_rdata;

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        cm_d       = cm_q;
        exp_d      = exp_q;
        nch_d      = nch_q;
        wr_base    = wr_q;
        free_space = '0;
        start_eval = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = wr_q;
        wr_last    = 1'b0;
        commit     = 1'b0;
        flag_set   = '0;
        if (Data_In_Valid) begin
            case (state_q)
                ST_FILL: begin
                    if (Data_In_ChIdx == exp_q) begin
                        ram_we = 1'b1;
                        wr_d   = wr_q + PW'(1);
                        if ({1'b0, exp_q} == nch_q - NCH_W'(1)) begin
                            wr_last = 1'b1;
                            commit  = 1'b1;
                            cm_d    = wr_q + PW'(1);
                            state_d = ST_SYNC;
                        end else begin
                            exp_d = exp_q + CH_W'(1);
                        end
                    end else begin
                        // Roll back the partial frame, then treat this sample as a fresh start candidate.
                        flag_set[FLAG_SEQ] = 1'b1;
                        wr_base    = cm_q;
                        wr_d       = cm_q;
                        state_d    = ST_SYNC;
                        start_eval = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (Data_In_ChIdx == '0) begin
                        start_eval = 1'b1;
                    end else if ({1'b0, Data_In_ChIdx} == nch_q - NCH_W'(1)) begin
                        state_d = ST_SYNC;
                    end
                end
                default: start_eval = 1'b1;
            endcase

            if (start_eval && Data_In_ChIdx == '0) begin
                nch_d      = Num_Ch;
                free_space = PW'(FIFO_DEPTH) - (wr_base - rd_q);
                if (Num_Ch == '0 || Num_Ch > NCH_W'(MAX_CHANNELS)) begin
                    flag_set[FLAG_CFG] = 1'b1;
                    state_d = ST_SYNC;
                end else if (int'(free_space) < int'(Num_Ch)) begin
                    flag_set[FLAG_OVF] = 1'b1;
                    state_d = ST_DROP;
                end else begin
                    ram_we    = 1'b1;
                    ram_waddr = wr_base;
                    wr_d      = wr_base + PW'(1);
                    exp_d     = CH_W'(1);
                    if (Num_Ch == NCH_W'(1)) begin
                        wr_last = 1'b1;
                        commit  = 1'b1;
                        cm_d    = wr_base + PW'(1);
                        state_d = ST_SYNC;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
        end
    end

    assign Data_Out_Valid = (cm_q != rd_q);
    assign do_read        = Data_Out_Valid && Data_Out_Ready;
    assign rd_d           = rd_q + PW'(do_read);
    assign fcnt_d         = fcnt_q + 16'(commit);
    // A set in the same cycle as a clear wins.
    assign flag_d         = flag_set | (flag_q & {3{~Clear_Status}});

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_SYNC;
            wr_q    <= '0;
            cm_q    <= '0;
            rd_q    <= '0;
            exp_q   <= '0;
            nch_q   <= '0;
            flag_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            cm_q    <= cm_d;
            rd_q    <= rd_d;
            exp_q   <= exp_d;
            nch_q   <= nch_d;
            flag_q  <= flag_d;
            fcnt_q  <= fcnt_d;
        end
    end

    mch_pack_ram #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (CLK),
        .we_i    (ram_we),
        .waddr_i (ram_waddr[AW-1:0]),
        .wdata_i ({Data_In_ChIdx, wr_last, Data_In}),
        .raddr_i (rd_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign Data_Out       = ram_rdata[DATA_WIDTH-1:0];
    assign Data_Out_Last  = ram_rdata[DATA_WIDTH];
    assign Data_Out_ChIdx = ram_rdata[EW-1 -: CH_W];
    assign Overflow       = flag_q[FLAG_OVF];
    assign Seq_Err        = flag_q[FLAG_SEQ];
    assign Cfg_Err        = flag_q[FLAG_CFG];
    assign Frame_Cnt      = fcnt_q;

endmodule

// File: tb/tb_mch_frame_packer.sv
// Directed bench for mch_frame_packer: a per-cycle vector table plus
// hand-written overflow and mid-frame reset sequences.
module tb_mch_frame_packer;

    logic        clk;
    logic        rst;
    logic [4:0]  num_ch;
    logic        clear_status;
    logic [23:0] data_in;
    logic        data_in_valid;
    logic [3:0]  data_in_chidx;
    logic [23:0] data_out;
    logic [3:0]  data_out_chidx;
    logic        data_out_last;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        overflow, seq_err, cfg_err;
    logic [15:0] frame_cnt;

    int n_total = 0;
    int n_bad   = 0;

    mch_frame_packer #(
        .DATA_WIDTH   (24),
        .MAX_CHANNELS (16),
        .FIFO_DEPTH   (64)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .Num_Ch         (num_ch),
        .Clear_Status   (clear_status),
        .Data_In        (data_in),
        .Data_In_Valid  (data_in_valid),
        .Data_In_ChIdx  (data_in_chidx),
        .Data_Out       (data_out),
        .Data_Out_ChIdx (data_out_chidx),
        .Data_Out_Last  (data_out_last),
        .Data_Out_Valid (data_out_valid),
        .Data_Out_Ready (data_out_ready),
        .Overflow       (overflow),
        .Seq_Err        (seq_err),
        .Cfg_Err        (cfg_err),
        .Frame_Cnt      (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  ch;
        logic [23:0] d;
        logic [4:0]  n;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [23:0] ed;
        logic [3:0]  ech;
        logic        el;
        logic [2:0]  efl;
        logic [15:0] efc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [3:0] ch, input logic [23:0] d,
                       input logic [4:0] n, input logic rdy, input logic clr,
                       input logic ev, input logic [23:0] ed, input logic [3:0] ech,
                       input logic el, input logic [2:0] efl, input logic [15:0] efc);
        vec_t r;
        r.v = v; r.ch = ch; r.d = d; r.n = n; r.rdy = rdy; r.clr = clr;
        r.ev = ev; r.ed = ed; r.ech = ech; r.el = el; r.efl = efl; r.efc = efc;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic drive(input logic v, input logic [3:0] ch, input logic [23:0] d,
                         input logic [4:0] n, input logic rdy, input logic clr);
        data_in_valid  = v;
        data_in_chidx  = ch;
        data_in        = d;
        num_ch         = n;
        data_out_ready = rdy;
        clear_status   = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mk(input int f, input int c);
        return 24'(32'hA000 + f * 256 + c);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] fc_base;
        rst = 1'b1;
        drive(0, 0, 0, 4, 0, 0);
        drive(0, 0, 0, 4, 0, 0);
        chk("reset_valid", 32'(data_out_valid), 0);
        chk("reset_fc", 32'(frame_cnt), 0);
        chk("reset_flags", 32'({overflow, seq_err, cfg_err}), 0);
        rst = 1'b0;

        // Basic 4-channel frame, drained with Ready held high.
        add(1, 0, 24'h000001, 4, 1, 0,  0, 0, 0, 0, 3'b000, 0);
        add(1, 1, 24'h000002, 4, 1, 0,  0, 0, 0, 0, 3'b000, 0);
        add(1, 2, 24'h000003, 4, 1, 0,  0, 0, 0, 0, 3'b000, 0);
        add(1, 3, 24'h000004, 4, 1, 0,  1, 24'h000001, 0, 0, 3'b000, 1);
        add(0, 0, 0,          4, 1, 0,  1, 24'h000002, 1, 0, 3'b000, 1);
        add(0, 0, 0,          4, 1, 0,  1, 24'h000003, 2, 0, 3'b000, 1);
        add(0, 0, 0,          4, 1, 0,  1, 24'h000004, 3, 1, 3'b000, 1);
        add(0, 0, 0,          4, 1, 0,  0, 0, 0, 0, 3'b000, 1);
        // Skipped channel: partial frame discarded, next frame intact.
        add(1, 0, 24'h000010, 4, 1, 0,  0, 0, 0, 0, 3'b000, 1);
        add(1, 1, 24'h000011, 4, 1, 0,  0, 0, 0, 0, 3'b000, 1);
        add(1, 3, 24'h000013, 4, 1, 0,  0, 0, 0, 0, 3'b010, 1);
        add(1, 0, 24'h000020, 4, 1, 0,  0, 0, 0, 0, 3'b010, 1);
        add(1, 1, 24'h000021, 4, 1, 0,  0, 0, 0, 0, 3'b010, 1);
        add(1, 2, 24'h000022, 4, 1, 0,  0, 0, 0, 0, 3'b010, 1);
        add(1, 3, 24'h000023, 4, 1, 0,  1, 24'h000020, 0, 0, 3'b010, 2);
        add(0, 0, 0,          4, 1, 0,  1, 24'h000021, 1, 0, 3'b010, 2);
        add(0, 0, 0,          4, 1, 0,  1, 24'h000022, 2, 0, 3'b010, 2);
        add(0, 0, 0,          4, 1, 0,  1, 24'h000023, 3, 1, 3'b010, 2);
        add(0, 0, 0,          4, 1, 1,  0, 0, 0, 0, 3'b000, 2);
        // A ch0 mid-frame restarts the frame with that very sample.
        add(1, 0, 24'h000040, 4, 1, 0,  0, 0, 0, 0, 3'b000, 2);
        add(1, 1, 24'h000041, 4, 1, 0,  0, 0, 0, 0, 3'b000, 2);
        add(1, 0, 24'h000050, 4, 1, 0,  0, 0, 0, 0, 3'b010, 2);
        add(1, 1, 24'h000051, 4, 1, 0,  0, 0, 0, 0, 3'b010, 2);
        add(1, 2, 24'h000052, 4, 1, 0,  0, 0, 0, 0, 3'b010, 2);
        add(1, 3, 24'h000053, 4, 1, 0,  1, 24'h000050, 0, 0, 3'b010, 3);
        add(0, 0, 0,          4, 1, 0,  1, 24'h000051, 1, 0, 3'b010, 3);
        add(0, 0, 0,          4, 1, 0,  1, 24'h000052, 2, 0, 3'b010, 3);
        add(0, 0, 0,          4, 1, 0,  1, 24'h000053, 3, 1, 3'b010, 3);
        add(0, 0, 0,          4, 1, 1,  0, 0, 0, 0, 3'b000, 3);
        // Single-channel frames commit immediately; Ready low holds the head.
        add(1, 0, 24'h000031, 1, 0, 0,  1, 24'h000031, 0, 1, 3'b000, 4);
        add(1, 0, 24'h000032, 1, 0, 0,  1, 24'h000031, 0, 1, 3'b000, 5);
        add(1, 0, 24'h000033, 1, 0, 0,  1, 24'h000031, 0, 1, 3'b000, 6);
        add(0, 0, 0,          1, 1, 0,  1, 24'h000032, 0, 1, 3'b000, 6);
        add(0, 0, 0,          1, 1, 0,  1, 24'h000033, 0, 1, 3'b000, 6);
        add(0, 0, 0,          1, 1, 0,  0, 0, 0, 0, 3'b000, 6);
        // Illegal channel counts; clear coinciding with a new error keeps the flag.
        add(1, 0, 24'h000077, 0, 1, 0,  0, 0, 0, 0, 3'b001, 6);
        add(1, 0, 24'h000078, 0, 1, 1,  0, 0, 0, 0, 3'b001, 6);
        add(0, 0, 0,          0, 1, 1,  0, 0, 0, 0, 3'b000, 6);
        add(1, 0, 24'h000079, 17, 1, 0, 0, 0, 0, 0, 3'b001, 6);
        add(0, 0, 0,          4, 1, 1,  0, 0, 0, 0, 3'b000, 6);
        // Non-zero channel while idle is ignored.
        add(1, 2, 24'h000099, 4, 1, 0,  0, 0, 0, 0, 3'b000, 6);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].n, tbl[i].rdy, tbl[i].clr);
            $display("vec %0d: valid=%0b data=%06h ch=%0d last=%0b flags=%03b fc=%0d",
                     i, data_out_valid, data_out, data_out_chidx, data_out_last,
                     {overflow, seq_err, cfg_err}, frame_cnt);
            chk($sformatf("v%0d_valid", i), 32'(data_out_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d_flags", i), 32'({overflow, seq_err, cfg_err}), 32'(tbl[i].efl));
            chk($sformatf("v%0d_fc", i), 32'(frame_cnt), 32'(tbl[i].efc));
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_data", i), 32'(data_out), 32'(tbl[i].ed));
                chk($sformatf("v%0d_ch", i), 32'(data_out_chidx), 32'(tbl[i].ech));
                chk($sformatf("v%0d_last", i), 32'(data_out_last), 32'(tbl[i].el));
            end
        end
        fc_base = tbl[tbl.size()-1].efc;

        // Overflow: four 16-channel frames fill the FIFO, the fifth is dropped whole.
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < 16; c++) begin
                drive(1, 4'(c), mk(f, c), 16, 0, 0);
                if (f == 4 && c == 0) chk("ovf_set", 32'(overflow), 1);
            end
            $display("frame %0d sent: valid=%0b fc=%0d ovf=%0b", f, data_out_valid, frame_cnt, overflow);
        end
        chk("ovf_fc", 32'(frame_cnt), 32'(fc_base + 16'd4));
        chk("ovf_valid", 32'(data_out_valid), 1);
        chk("ovf_no_seq", 32'(seq_err), 0);
        drive(1, 1, 24'hFFFFFF, 16, 0, 0);
        chk("ovf_idle_fc", 32'(frame_cnt), 32'(fc_base + 16'd4));
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(data_out_valid), 1);
            chk($sformatf("drain%0d_data", i), 32'(data_out), 32'(mk(i / 16, i % 16)));
            chk($sformatf("drain%0d_last", i), 32'(data_out_last), 32'((i % 16) == 15));
            $display("drain %0d: data=%06h ch=%0d last=%0b", i, data_out, data_out_chidx, data_out_last);
            drive(0, 0, 0, 16, 1, 0);
        end
        chk("drain_empty", 32'(data_out_valid), 0);

        // Reset in mid-frame, then a clean frame.
        drive(0, 0, 0, 4, 1, 1);
        drive(1, 0, 24'h0000A0, 4, 1, 0);
        drive(1, 1, 24'h0000A1, 4, 1, 0);
        rst = 1'b1;
        drive(0, 0, 0, 4, 1, 0);
        rst = 1'b0;
        $display("mid-frame reset: valid=%0b fc=%0d", data_out_valid, frame_cnt);
        chk("rst_valid", 32'(data_out_valid), 0);
        chk("rst_fc", 32'(frame_cnt), 0);
        chk("rst_flags", 32'({overflow, seq_err, cfg_err}), 0);
        drive(1, 0, 24'h0000B0, 4, 1, 0);
        drive(1, 1, 24'h0000B1, 4, 1, 0);
        drive(1, 2, 24'h0000B2, 4, 1, 0);
        chk("post_rst_hidden", 32'(data_out_valid), 0);
        drive(1, 3, 24'h0000B3, 4, 1, 0);
        chk("post_rst_fc", 32'(frame_cnt), 1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("post_rst%0d_valid", c), 32'(data_out_valid), 1);
            chk($sformatf("post_rst%0d_data", c), 32'(data_out), 32'(24'h0000B0 + 24'(c)));
            chk($sformatf("post_rst%0d_ch", c), 32'(data_out_chidx), 32'(c));
            chk($sformatf("post_rst%0d_last", c), 32'(data_out_last), 32'(c == 3));
            $display("post-reset word %0d: data=%06h last=%0b", c, data_out, data_out_last);
            drive(0, 0, 0, 4, 1, 0);
        end
        chk("post_rst_empty", 32'(data_out_valid), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mch_frame_packer.md
MCH_FRAME_PACKER -- requirements
Module: mch_frame_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 24: sample width.
REQ-002 Parameter MAX_CHANNELS, default 16: maximum channels per frame, at most 16.
REQ-003 Parameter FIFO_DEPTH, default 64: number of entries; power of two and at least 2*MAX_CHANNELS.
REQ-004 Port CLK, input, 1: single clock; all logic on the rising edge.
REQ-005 Port RST, input, 1: reset, synchronous and active-high.
REQ-006 Port Num_Ch, input, 5: channels per frame, legal range 1..MAX_CHANNELS.
REQ-007 Port Clear_Status, input, 1: clears the sticky flags.
REQ-008 Ports Data_In (input, DATA_WIDTH), Data_In_Valid (input, 1), Data_In_ChIdx (input, 4): sample stream from the last half-band stage; no backpressure.
REQ-009 Ports Data_Out (output, DATA_WIDTH), Data_Out_ChIdx (output, 4), Data_Out_Last (output, 1): head FIFO entry; Last marks the final channel of a frame.
REQ-010 Ports Data_Out_Valid (output, 1) and Data_Out_Ready (input, 1): transfer occurs when both are high.
REQ-011 Ports Overflow, Seq_Err, Cfg_Err (outputs, 1 each): sticky flags.
REQ-012 Port Frame_Cnt, output, 16: count of committed frames; wraps at 16 bits.

Function
REQ-013 The block SHALL pack per-channel samples into frame-atomic FIFO entries {ChIdx, Last, Data}; an incomplete frame is never visible at the output.
REQ-014 The FIFO SHALL keep three pointers, each log2(FIFO_DEPTH)+1 bits: write (wr), commit (cm) and read (rd).
- Occupancy = wr-rd.
- Data_Out_Valid = (cm != rd).
REQ-015 The input state machine SHALL have states SYNC, FILL and DROP.
REQ-016 In SYNC, a valid sample with ChIdx==0 SHALL start a frame and latch Num_Ch:
- If free space >= Num_Ch: write the sample, set expected index to 1, go to FILL.
- Otherwise: set Overflow and go to DROP.
- A valid sample with ChIdx!=0 is discarded.
REQ-017 In FILL, a valid sample with ChIdx==expected SHALL be written; when the index equals latched Num_Ch-1, Last=1, cm<=wr+1 and the state returns to SYNC.
REQ-018 In FILL, a valid sample with ChIdx!=expected SHALL:
- set wr<=cm, discarding the partial frame;
- set Seq_Err;
- re-evaluate the same sample as in SYNC in that cycle.
REQ-019 In DROP, samples SHALL be discarded until a valid sample with ChIdx==latched Num_Ch-1, then the state goes to SYNC; a ChIdx==0 sample is re-evaluated as in SYNC.
REQ-020 Num_Ch==1 SHALL commit in the same cycle as the ChIdx==0 write, with Last=1, and the state stays in SYNC.
REQ-021 Num_Ch of 0 or greater than MAX_CHANNELS at a frame start SHALL drop the sample, set Cfg_Err, and keep the state in SYNC.
REQ-022 Output SHALL be first-word-fall-through: Data_Out_Valid rises the cycle after the commit edge, and the output holds stable while Valid is high and Ready is low.
REQ-023 A read and a write or commit in the same cycle SHALL both take effect; free space is computed from the pre-edge pointers.
REQ-024 Frame_Cnt SHALL increment on every commit.
REQ-025 Sticky flags SHALL be cleared by Clear_Status; when a set and a clear coincide, the set wins.

Reset
REQ-026 While RST is high at an edge, all of the following SHALL hold:
- wr, cm and rd = 0;
- state = SYNC;
- Frame_Cnt = 0;
- all flags = 0;
- Data_Out_Valid = 0.
REQ-027 Reset in mid-frame SHALL discard all FIFO contents; Data_Out and Data_Out_ChIdx are don't-care while Valid is low.

Structure
REQ-028 Package mch_pack_pkg SHALL hold the SYNC/FILL/DROP state encoding, the channel index width (4) and the entry layout widths.
REQ-029 Storage SHALL be one sub-module, mch_pack_ram: a simple dual-port FIFO_DEPTH x (DATA_WIDTH+5) array with synchronous write and asynchronous read.

Verification
REQ-030 Num_Ch=4 with samples ch0..3 = 0x000001..0x000004 and Ready=1 SHALL produce the four samples in order, Last on ch3, Valid the cycle after ch3, and Frame_Cnt=1.
REQ-031 Num_Ch=4 with sequence ch0, ch1, ch3 SHALL produce no output, set Seq_Err=1 and leave cm unchanged; a following ch0..3 frame SHALL output normally.
REQ-032 Num_Ch=16 and FIFO_DEPTH=64 with Ready=0 SHALL commit 4 frames; the 5th frame SHALL be dropped whole with Overflow=1; with Ready=1 after that, 64 words are output then Valid=0.
REQ-033 Num_Ch=1 with 3 samples SHALL produce 3 entries, each with Last=1, and Frame_Cnt=3.
REQ-034 Num_Ch=0 with a sample on ch0 SHALL set Cfg_Err=1 with no write; Clear_Status in the same cycle as a new error SHALL leave the flag at 1.
REQ-035 RST asserted after ch0..1 of a 4-channel frame SHALL give Valid=0 and Frame_Cnt=0; the next full frame SHALL output correctly.
